// File: rtl/button_event_queue_pkg.sv
// Shared types for the button event queue: FSM state encoding.
package button_event_queue_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_e;

endpackage

// File: rtl/button_event_queue_if.sv
// Event handshake between the queue (master) and the control FSM (slave).
interface button_event_queue_if #(
   parameter int CODE_W = 2
) ();

   logic              req;
   logic              ack;
   logic [CODE_W-1:0] code;

   modport master (output req, output code, input ack);
   modport slave  (input req, input code, output ack);

endinterface

// File: rtl/button_event_queue_event_counter.sv
// Per-channel saturating pending-press counter; sat_hit flags a press dropped at max.
module event_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             sat_hit
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Simultaneous inc and dec cancel, even at max, so no overflow is reported.
   always_comb begin
      cnt_d   = cnt_q;
      sat_hit = 1'b0;
      if (inc && !dec) begin
         if (cnt_q == CNT_MAX) sat_hit = 1'b1;
         else                  cnt_d   = cnt_q + 1'b1;
      end else if (dec && !inc && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/button_event_queue.sv
// Latches debounced press pulses per channel and presents them one at a time
// on a req/ack handshake with round-robin channel selection.
module button_event_queue
   import button_event_queue_pkg::*;
#(
   parameter int N      = 4,
   parameter int CNT_W  = 2,
   parameter int CODE_W = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           pulse_in,
   input  logic                   ovf_clr,
   button_event_queue_if.master   evt,
   output logic                   pending,
   output logic [N-1:0]           ovf
);

   state_e            state_q;
   logic              req_q;
   logic [CODE_W-1:0] code_q, code_d;
   logic [CODE_W-1:0] last_q;
   logic [N-1:0]      ovf_q, ovf_d;
   logic              pending_q;

   logic [CNT_W-1:0]  cnt [N];
   logic [N-1:0]      dec, sat_hit, nz, nz_nxt;
   logic              any_nz;

   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign dec[gi] = (state_q == ST_PRESENT) && evt.ack && (code_q == CODE_W'(gi));

      event_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .inc     (pulse_in[gi]),
         .dec     (dec[gi]),
         .cnt     (cnt[gi]),
         .sat_hit (sat_hit[gi])
      );

      assign nz[gi] = (cnt[gi] != '0);
      // Nonzero after this edge unless the last queued press is being consumed.
      assign nz_nxt[gi] = pulse_in[gi] |
                          (nz[gi] & !(dec[gi] && !pulse_in[gi] && cnt[gi] == CNT_W'(1)));
   end

   assign any_nz = |nz;

   // Round-robin search starting just after the last served channel.
   always_comb begin
      logic found;
      found  = 1'b0;
      code_d = '0;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (int'(last_q) + k) % N;
         if (!found && ((nz >> idx) & N'(1)) != '0) begin
            found  = 1'b1;
            code_d = CODE_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         code_q  <= '0;
         last_q  <= CODE_W'(N - 1);
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (any_nz) begin
                  code_q  <= code_d;
                  req_q   <= 1'b1;
                  state_q <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (evt.ack) begin
                  last_q  <= code_q;
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // A new drop wins over a clear landing in the same cycle.
   assign ovf_d = sat_hit | (ovf_q & ~{N{ovf_clr}});

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         ovf_q     <= ovf_d;
         pending_q <= |nz_nxt;
      end
   end

   assign evt.req  = req_q;
   assign evt.code = code_q;
   assign pending  = pending_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: stimulus pushes expected event codes,
// a negedge monitor pops and compares whenever a new event is presented.
module tb_button_event_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pulse_in;
   logic       ovf_clr;
   logic       pending;
   logic [3:0] ovf;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   button_event_queue_if #(.CODE_W(2)) evt ();

   button_event_queue #(.N(4), .CNT_W(2), .CODE_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (pulse_in),
      .ovf_clr  (ovf_clr),
      .evt      (evt),
      .pending  (pending),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!evt.req && n < 100) begin
         tick();
         n++;
      end
      if (!evt.req) check("req_timeout", 0, 1);
   endtask

   task automatic do_ack();
      wait_req();
      evt.ack = 1'b1;
      tick();
      evt.ack = 1'b0;
   endtask

   // Monitor: each rising req must match the next expected channel code.
   logic       req_prev  = 1'b0;
   logic [1:0] code_prev = '0;
   always @(negedge clk) begin
      if (rst) begin
         req_prev = 1'b0;
      end else begin
         if (evt.req && !req_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got code %0d expected none", evt.code);
            end else begin
               check("event_code", int'(evt.code), exp_q.pop_front());
            end
         end else if (evt.req && req_prev) begin
            check("code_stable", int'(evt.code), int'(code_prev));
         end
         req_prev  = evt.req;
         code_prev = evt.code;
      end
   end

   initial begin
      rst      = 1'b1;
      pulse_in = '0;
      ovf_clr  = 1'b0;
      evt.ack  = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      check("reset_req", int'(evt.req), 0);
      check("reset_code", int'(evt.code), 0);
      check("reset_pending", int'(pending), 0);
      check("reset_ovf", int'(ovf), 0);

      // 1: single press on ch2
      exp_q.push_back(2);
      pulse_in = 4'b0100;
      tick();
      pulse_in = '0;
      check("t1_pending_early", int'(pending), 1);
      check("t1_req_early", int'(evt.req), 0);
      tick();
      check("t1_req_latency", int'(evt.req), 1);
      check("t1_code", int'(evt.code), 2);
      do_ack();
      check("t1_req_after_ack", int'(evt.req), 0);
      check("t1_pending_after_ack", int'(pending), 0);

      // 2: three presses on ch0 before any ack
      repeat (3) exp_q.push_back(0);
      pulse_in = 4'b0001;
      repeat (3) tick();
      pulse_in = '0;
      repeat (3) do_ack();
      check("t2_pending", int'(pending), 0);
      check("t2_ovf", int'(ovf), 0);
      repeat (4) tick();
      check("t2_no_extra_req", int'(evt.req), 0);

      // 3: four presses on ch0 saturate the counter
      repeat (3) exp_q.push_back(0);
      pulse_in = 4'b0001;
      repeat (4) tick();
      pulse_in = '0;
      check("t3_ovf_set", int'(ovf), 1);
      check("t3_pending", int'(pending), 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("t3_ovf_cleared", int'(ovf), 0);
      repeat (3) do_ack();
      check("t3_pending_done", int'(pending), 0);
      repeat (4) tick();
      check("t3_exactly_three", int'(evt.req), 0);

      // 4: ch1 and ch3 together, ch1 re-pressed while ch3 is presented
      exp_q.push_back(1);
      exp_q.push_back(3);
      exp_q.push_back(1);
      pulse_in = 4'b1010;
      tick();
      pulse_in = '0;
      do_ack();
      wait_req();
      check("t4_second_code", int'(evt.code), 3);
      pulse_in = 4'b0010;
      tick();
      pulse_in = '0;
      do_ack();
      do_ack();
      check("t4_pending_done", int'(pending), 0);

      // 5: press and ack on saturated ch0 in the same cycle
      repeat (4) exp_q.push_back(0);
      pulse_in = 4'b0001;
      repeat (3) tick();
      pulse_in = '0;
      check("t5_req_presented", int'(evt.req), 1);
      evt.ack  = 1'b1;
      pulse_in = 4'b0001;
      tick();
      evt.ack  = 1'b0;
      pulse_in = '0;
      check("t5_ovf_not_set", int'(ovf), 0);
      check("t5_pending", int'(pending), 1);
      repeat (3) do_ack();
      check("t5_pending_done", int'(pending), 0);

      // 6: reset while presenting, with events queued and ovf set
      exp_q.push_back(1);
      pulse_in = 4'b1110;
      tick();
      pulse_in = 4'b1000;
      repeat (3) tick();
      pulse_in = '0;
      check("t6_ovf_before_reset", int'(ovf), 8);
      check("t6_req_before_reset", int'(evt.req), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_req_after_reset", int'(evt.req), 0);
      check("t6_code_after_reset", int'(evt.code), 0);
      check("t6_pending_after_reset", int'(pending), 0);
      check("t6_ovf_after_reset", int'(ovf), 0);
      evt.ack = 1'b1;
      tick();
      evt.ack = 1'b0;
      repeat (4) tick();
      check("t6_req_idle", int'(evt.req), 0);
      check("t6_pending_idle", int'(pending), 0);

      check("expected_queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
